// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus send sequencer feeding a UART transmitter.
// A byte is offered only while the transmitter reports neither active nor done.
// Each offer is a one-cycle tx_valid strobe. Every completed frame is counted once.
module uart_tx_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [7:0]    wr_data,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level,
  output logic          overflow,
  input  logic          ovf_clr,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_active,
  input  logic          tx_done,
  output logic          busy,
  output logic [15:0]   sent_count
);

  typedef enum logic [1:0] {IDLE, SEND, WAIT_HI, WAIT_LO} state_t;

  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          pop, push;
  logic [AW:0]   level_nxt;

  // The transmitter may still be finishing a frame begun before a feeder
  // reset, so both of its status lines gate the next pop.
  assign pop  = (state == IDLE) && !empty && !tx_active && !tx_done;
  // A full FIFO can still accept a byte when a pop frees a slot in the same cycle.
  assign push = wr_en && (!full || pop);

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_nxt = level;
    if (push && !pop)      level_nxt = level + 1'b1;
    else if (!push && pop) level_nxt = level - 1'b1;
  end

  // Storage array has no reset; the occupancy count guards against reading stale slots.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointers, occupancy flags and the sticky overflow bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      empty    <= 1'b1;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      full  <= (level_nxt == FULL_LVL);
      empty <= (level_nxt == '0);
      if (ovf_clr)                      overflow <= 1'b0;
      else if (wr_en && full && !pop)   overflow <= 1'b1;
    end
  end

  // Send sequencer: strobe, wait for done to rise (count), wait for done to fall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      tx_data    <= 8'h00;
      tx_valid   <= 1'b0;
      busy       <= 1'b0;
      sent_count <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          tx_valid <= 1'b0;
          if (pop) begin
            tx_data  <= mem[rd_ptr];
            tx_valid <= 1'b1;
            busy     <= 1'b1;
            state    <= SEND;
          end
        end
        SEND: begin
          tx_valid <= 1'b0;
          state    <= WAIT_HI;
        end
        WAIT_HI: begin
          // Done lasts two cycles; counting on entry to WAIT_LO counts the frame once.
          if (tx_done) begin
            sent_count <= sent_count + 16'd1;
            state      <= WAIT_LO;
          end
        end
        WAIT_LO: begin
          if (!tx_done) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          tx_valid <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized scoreboard bench for uart_tx_feeder with a behavioural UART transmitter.
module tb_uart_tx_feeder;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int CPB   = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wr_en, ovf_clr;
  logic [7:0]    wr_data;
  logic          full, empty, overflow, tx_valid, busy;
  logic [AW:0]   level;
  logic [7:0]    tx_data;
  logic          tx_active, tx_done;
  logic [15:0]   sent_count;

  // Behavioural transmitter state. stall holds tx_active high.
  logic act, tdone, ser, stall;
  assign tx_active = act | stall;
  assign tx_done   = tdone;

  uart_tx_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .ovf_clr(ovf_clr), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_active(tx_active), .tx_done(tx_done), .busy(busy),
    .sent_count(sent_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  // Reference model: byte queue, occupancy, sticky overflow, frame count.
  logic [7:0]  exp_q[$];
  logic [7:0]  ser_q[$];
  int          mcount = 0;
  logic        movf = 1'b0;
  logic [15:0] msent = 16'h0;
  logic        outst = 1'b0;
  logic [7:0]  mlast = 8'h00;
  logic [7:0]  last_rx = 8'h00;
  int          peak = 0;

  // Transmitter: start bit, 8 data bits LSB first, stop bit, then done for 2 cycles.
  initial begin
    logic [7:0] b;
    ser = 1'b1; act = 1'b0; tdone = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_valid === 1'b1) begin
        b = tx_data; act = 1'b1; ser = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          ser = b[i];
          repeat (CPB) @(negedge clk);
        end
        ser = 1'b1;
        repeat (CPB) @(negedge clk);
        act = 1'b0; tdone = 1'b1;
        repeat (2) @(negedge clk);
        tdone = 1'b0;
      end
    end
  end

  // Serial line decoder: sample mid-bit, compare against the strobed byte.
  initial begin
    logic [7:0] rb;
    forever begin
      @(negedge ser);
      repeat (2) @(posedge clk);
      chk("serial_start", {31'd0, ser}, 32'd0);
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        rb[i] = ser;
      end
      repeat (CPB) @(posedge clk);
      chk("serial_stop", {31'd0, ser}, 32'd1);
      if (ser_q.size() == 0) begin
        total++; bad++;
        $display("FAIL serial_unexpected: got %0h want none", rb);
      end else chk("serial_byte", {24'd0, rb}, {24'd0, ser_q.pop_front()});
      last_rx = rb;
    end
  end

  // Monitor: sample inputs at the edge, check outputs 1 time unit later.
  initial begin
    logic sw, sc, sa, sd, popped, dprev, vprev;
    logic [7:0] sdat, e;
    dprev = 1'b0; vprev = 1'b0;
    forever begin
      @(posedge clk);
      sw = wr_en; sdat = wr_data; sc = ovf_clr; sa = tx_active; sd = tx_done;
      #1;
      if (!rst_n) begin
        exp_q.delete(); mcount = 0; movf = 1'b0; msent = 16'h0; outst = 1'b0; mlast = 8'h00;
        chk("rst_outputs", {full, empty, level, overflow, tx_valid, busy},
                           {1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0});
        chk("rst_data", {tx_data, sent_count}, 32'd0);
      end else begin
        popped = tx_valid;
        if (popped) begin
          chk("strobe_guard", {30'd0, sa, sd}, 32'd0);
          chk("strobe_width", {31'd0, vprev}, 32'd0);
          if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL strobe_unexpected: got %0h want none", tx_data);
          end else begin
            e = exp_q.pop_front();
            chk("tx_data", {24'd0, tx_data}, {24'd0, e});
            mlast = e; outst = 1'b1; ser_q.push_back(e);
          end
        end else chk("tx_hold", {24'd0, tx_data}, {24'd0, mlast});
        if (sw) begin
          if (mcount < DEPTH || popped) begin exp_q.push_back(sdat); mcount++; end
          else movf = 1'b1;
        end
        if (popped) mcount--;
        if (sc) movf = 1'b0;
        if (sd && !dprev && outst) begin msent = msent + 16'd1; outst = 1'b0; end
        chk("level", {27'd0, level}, mcount);
        chk("full", {31'd0, full}, {31'd0, mcount == DEPTH});
        chk("empty", {31'd0, empty}, {31'd0, mcount == 0});
        chk("overflow", {31'd0, overflow}, {31'd0, movf});
        chk("sent_count", {16'd0, sent_count}, {16'd0, msent});
        if (outst) chk("busy_frame", {31'd0, busy}, 32'd1);
        if (int'(level) > peak) peak = int'(level);
      end
      dprev = sd; vprev = tx_valid;
    end
  end

  task automatic wr(input logic [7:0] d);
    wr_en = 1'b1; wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || ser_q.size() != 0 || busy || tx_active || tx_done) && n < 5000) begin
      @(negedge clk); n++;
    end
    if (n >= 5000) begin
      total++; bad++;
      $display("FAIL drain_timeout: got busy=%0b level=%0d want idle", busy, level);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'h00; ovf_clr = 1'b0; stall = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Single byte: strobe one cycle after the push edge.
    wr(8'hA5);
    chk("t1_no_early_strobe", {31'd0, tx_valid}, 32'd0);
    @(negedge clk);
    chk("t1_strobe", {23'd0, tx_valid, tx_data}, {23'd0, 1'b1, 8'hA5});
    drain();
    chk("t1_done", {sent_count, 14'd0, busy, empty}, {16'd1, 14'd0, 1'b0, 1'b1});
    chk("t1_serial", {24'd0, last_rx}, 32'hA5);

    // Burst of three.
    peak = 0;
    wr(8'h01); wr(8'h02); wr(8'h03);
    drain();
    chk("t2_peak", peak, 2);
    chk("t2_sent", {16'd0, sent_count}, 32'd4);

    // Stalled transmitter: fill, overflow, clear-priority, push+pop when full.
    stall = 1'b1;
    for (int i = 0; i <= DEPTH; i++) wr(8'h10 + 8'(i));
    chk("t3_full", {26'd0, full, level}, {26'd0, 1'b1, 5'd16});
    chk("t3_ovf", {31'd0, overflow}, 32'd1);
    wr_en = 1'b1; wr_data = 8'h55; ovf_clr = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; ovf_clr = 1'b0;
    chk("t3_clr_prio", {31'd0, overflow}, 32'd0);
    stall = 1'b0; wr_en = 1'b1; wr_data = 8'hEE;
    @(negedge clk);
    wr_en = 1'b0;
    chk("t4_pushpop_level", {26'd0, full, level}, {26'd0, 1'b1, 5'd16});
    chk("t4_pushpop_ovf", {31'd0, overflow}, 32'd0);
    drain();
    chk("t4_last_byte", {24'd0, last_rx}, 32'hEE);

    // Reset while the transmitter is in its data bits.
    wr(8'h77);
    begin
      int n = 0;
      while (!act && n < 50) begin @(negedge clk); n++; end
      chk("t5_frame_started", {31'd0, act}, 32'd1);
    end
    repeat (12) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    wr(8'h3C);
    drain();
    chk("t5_sent", {16'd0, sent_count}, 32'd1);
    chk("t5_serial", {24'd0, last_rx}, 32'h3C);

    // Random traffic.
    for (int i = 0; i < 300; i++) begin
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_data = 8'($urandom);
      ovf_clr = ($urandom_range(0, 19) == 0);
      @(negedge clk);
    end
    wr_en = 1'b0; ovf_clr = 1'b0;
    drain();
    chk("rand_idle", {30'd0, busy, empty}, 32'd1);

    // Counter wrap.
    force dut.sent_count = 16'hFFFF;
    msent = 16'hFFFF;
    @(negedge clk);
    release dut.sent_count;
    wr(8'($urandom));
    drain();
    chk("t6_wrap", {16'd0, sent_count}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
